// File: rtl/fm_audio_decim.sv
// Boxcar decimator with optional first-order de-emphasis and a 1-deep output hold register.
// Define AUDIO_DEEMPH_EN to enable the de-emphasis filter; otherwise stage 2 is a plain shift.
module fm_audio_decim #(
    parameter int IN_W         = 12,
    parameter int OUT_W        = 16,
    parameter int DECIM        = 8,
    parameter int DEEMPH_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              overrun_cnt
);

    localparam int LG    = $clog2(DECIM);
    localparam int ACC_W = IN_W + LG;
    localparam int SH    = OUT_W - IN_W;

    if (DECIM < 2 || DECIM > 256 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
        $error("DECIM must be a power of two in 2..256");
    end
    if (DEEMPH_SHIFT < 1 || DEEMPH_SHIFT > 8) begin : g_bad_shift
        $error("DEEMPH_SHIFT must be in 1..8");
    end
    if (OUT_W < IN_W) begin : g_bad_width
        $error("OUT_W must be >= IN_W");
    end

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [LG-1:0]           phase_q, phase_d;
    logic signed [IN_W-1:0]  dec_q, dec_d;
    logic                    dec_vld_q, dec_vld_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic [7:0]              ovr_q, ovr_d;

    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    last;
    logic signed [OUT_W-1:0] x;
    logic signed [OUT_W-1:0] y;
    logic                    can_load;

    assign in_ext = ACC_W'(in_data);
    assign sum    = (phase_q == '0) ? in_ext : acc_q + in_ext;
    assign last   = in_valid && (phase_q == LG'(DECIM - 1));

    always_comb begin
        acc_d     = acc_q;
        phase_d   = phase_q;
        dec_d     = dec_q;
        dec_vld_d = last;
        if (in_valid) begin
            acc_d   = sum;
            phase_d = phase_q + LG'(1);
        end
        // Dropping the low LG bits of a signed sum is a floor-rounded mean.
        if (last) begin
            dec_d = sum[ACC_W-1:LG];
        end
    end

    assign x = OUT_W'(dec_q) <<< SH;

`ifdef AUDIO_DEEMPH_EN
    localparam int ZW = OUT_W + DEEMPH_SHIFT;

    logic signed [ZW-1:0] z_q, z_d;

    // Intermediate wrap is harmless: the final sum always fits in ZW bits.
    always_comb begin
        z_d = z_q;
        if (dec_vld_q) begin
            z_d = z_q + ZW'(x) - (z_q >>> DEEMPH_SHIFT);
        end
    end

    assign y = z_d[ZW-1:DEEMPH_SHIFT];

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q <= '0;
        end else begin
            z_q <= z_d;
        end
    end
`else
    assign y = x;
`endif

    assign can_load = !out_valid_q || out_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ovr_d       = ovr_q;
        if (dec_vld_q && can_load) begin
            out_data_d  = y;
            out_valid_d = 1'b1;
        end else if (dec_vld_q) begin
            if (ovr_q != 8'hFF) begin
                ovr_d = ovr_q + 8'd1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            phase_q     <= '0;
            dec_q       <= '0;
            dec_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovr_q       <= '0;
        end else begin
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            dec_q       <= dec_d;
            dec_vld_q   <= dec_vld_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_fm_audio_decim.sv
// Scoreboard bench for fm_audio_decim: block-mean reference model feeding a
// queue, and a monitor that tracks the 1-deep output buffer and drop count.
module tb_fm_audio_decim;

    localparam int IN_W  = 12;
    localparam int OUT_W = 16;
    localparam int DECIM = 8;
    localparam int S     = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic signed [IN_W-1:0]  in_data = '0;
    logic                    in_valid = 1'b0;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [7:0]              overrun_cnt;

    fm_audio_decim #(
        .IN_W(IN_W), .OUT_W(OUT_W), .DECIM(DECIM), .DEEMPH_SHIFT(S)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint val;
        int     at;
    } ent_t;

    ent_t   pend[$];
    int     edge_n = 0;
    int     checks = 0;
    int     failures = 0;
    int     accepted = 0;

    longint blk_sum = 0;
    int     blk_n = 0;
    longint z = 0;

    logic   exp_held = 1'b0;
    longint exp_val = 0;
    int     exp_ovr = 0;
    bit     mon_on = 1'b0;

    always @(posedge clk) edge_n++;

    function automatic longint floordiv(longint a, longint d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, edge_n, act, exp);
        end
    endfunction

    // Reference: mean of each block of DECIM samples, scaled, then optional IIR.
    function automatic void model_sample(longint d);
        longint mean;
        longint xs;
        longint y;
        blk_sum += d;
        blk_n++;
        if (blk_n == DECIM) begin
            mean = floordiv(blk_sum, DECIM);
            xs   = mean * (longint'(1) << (OUT_W - IN_W));
`ifdef AUDIO_DEEMPH_EN
            z = z + xs - floordiv(z, longint'(1) << S);
            y = floordiv(z, longint'(1) << S);
`else
            y = xs;
`endif
            pend.push_back('{val: y, at: edge_n + 2});
            blk_sum = 0;
            blk_n   = 0;
        end
    endfunction

    // Monitor: compare state after the last edge, then predict the next edge.
    always @(negedge clk) begin
        ent_t e;
        int   nxt;
        bit   acc;
        if (mon_on) begin
            chk("out_valid", longint'(out_valid), longint'(exp_held));
            chk("out_data", longint'(out_data), exp_val);
            chk("overrun_cnt", longint'(overrun_cnt), longint'(exp_ovr));
        end
        nxt = edge_n + 1;
        if (rst) begin
            exp_held = 1'b0;
            exp_val  = 0;
            exp_ovr  = 0;
            pend.delete();
            mon_on   = 1'b1;
        end else begin
            acc = exp_held && out_ready;
            if (pend.size() > 0 && pend[0].at == nxt) begin
                e = pend.pop_front();
                if (!exp_held || out_ready) begin
                    exp_held = 1'b1;
                    exp_val  = e.val;
                end else if (exp_ovr < 255) begin
                    exp_ovr++;
                end
            end else if (acc) begin
                exp_held = 1'b0;
            end
            if (acc) accepted++;
        end
    end

    task automatic drive(input logic v, input logic signed [IN_W-1:0] d,
                         input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        if (v) model_sample(longint'(d));
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        blk_sum  = 0;
        blk_n    = 0;
        z        = 0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic burst(input int n, input logic signed [IN_W-1:0] d,
                         input logic r);
        for (int i = 0; i < n; i++) drive(1'b1, d, r);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) drive(1'b0, '0, r);
    endtask

    initial begin
        do_reset(3);
        idle(2, 1'b1);

        burst(32, 12'sd100, 1'b1);
        idle(4, 1'b1);
        burst(16, -12'sd2048, 1'b1);
        idle(4, 1'b1);
        burst(16, 12'sd2047, 1'b1);
        idle(4, 1'b1);

        burst(16, 12'sd100, 1'b0);
        idle(4, 1'b0);
        idle(4, 1'b1);

        burst(5, 12'sd800, 1'b1);
        do_reset(2);
        burst(8, 12'sd0, 1'b1);
        idle(4, 1'b1);

        // Hold a result, then accept exactly as the next one loads.
        burst(8, 12'sd300, 1'b0);
        burst(7, -12'sd300, 1'b0);
        burst(1, -12'sd300, 1'b0);
        idle(1, 1'b1);
        idle(4, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(1);
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  IN_W'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 300; i++) drive(1'b1, 12'sd2047, 1'b0);
        idle(12, 1'b1);

        chk("scoreboard_drained", longint'(pend.size()), 0);
        checks++;
        if (accepted < 50) begin
            failures++;
            $display("FAIL accept_count: got %0d, expected at least 50", accepted);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
